aplic_msi_sched: RTL and testbench
==================================

Name: aplic_msi_sched

Overview:
- Sequences MSI delivery for one APLIC interrupt domain in MSI delivery mode (domaincfg.DM=1).
- Arbitrates between two requesters: pending-and-enabled sources (round-robin) and a software genmsi request.
- Builds each MSI write (address from the domain's MSI base PPN plus the target hart index; data is the EIID) and issues it over a valid/ready handshake to the bus-master side.
- After a source MSI is accepted, pulses a pending-clear request back to the APLIC register file.

Parameters:
- NR_SRC, 32, number of interrupt source slots; index 0 is reserved and never granted.
- SRC_W, $clog2(NR_SRC), width of a source index.

Ports:
- i_clk  in  1  clock
- ni_rst  in  1  reset
- i_domaincfg_ie  in  1  domain interrupt enable
- i_domaincfg_dm  in  1  delivery mode; 1 = MSI
- i_pending  in  NR_SRC  pending bits
- i_enabled  in  NR_SRC  enable bits
- i_target  in  NR_SRC*32  target registers, flattened; source k at [32k+31:32k]; hi=[31:18], gi=[17:12], eiid=[10:0]
- i_msi_base_ppn  in  44  MSI base PPN for this domain (mmsiaddrcfg or smsiaddrcfg)
- i_genmsi_valid  in  1  one-cycle strobe for a genmsi write
- i_genmsi_hi  in  14  genmsi hart index
- i_genmsi_eiid  in  11  genmsi EIID
- o_genmsi_busy  out  1  genmsi.busy read value
- o_msi_valid  out  1  MSI write request
- i_msi_ready  in  1  MSI write accepted
- o_msi_addr  out  64  MSI target address
- o_msi_data  out  32  MSI data
- o_clrip_valid  out  1  clear-pending pulse
- o_clrip_idx  out  SRC_W  source whose pending bit to clear

Behaviour:
- Reset and clocking
  - Reset is synchronous and active-low on ni_rst; single clock i_clk.
  - On reset, all outputs are 0, FSM is IDLE, rr_ptr=0, last_was_gen=0, genmsi holding register is cleared.
- Eligibility
  - A source k (1..NR_SRC-1) is eligible when i_pending[k] & i_enabled[k] & i_domaincfg_ie & i_domaincfg_dm & (eiid_k != 0).
  - A source with eiid=0 is never sent; its pending bit is left untouched.
- genmsi capture
  - When i_genmsi_valid=1 and o_genmsi_busy=0, hi and eiid are latched and o_genmsi_busy goes to 1 on the next cycle.
  - Strobes while busy are ignored.
  - genmsi does not depend on ie; it does require dm=1, otherwise the strobe is ignored.
- FSM: IDLE, SEND, GAP
  - IDLE, when a genmsi is held or any source is eligible:
    - Grant genmsi if one is held, unless last_was_gen=1 and a source is eligible; in that case grant the source.
    - Source selection is round-robin: first eligible index searching upward from rr_ptr+1, wrapping from NR_SRC-1 to 1, with 0 skipped.
    - Register addr/data, set o_msi_valid=1, go to SEND. o_msi_valid rises the cycle after eligibility is first seen in IDLE.
  - SEND:
    - o_msi_valid, o_msi_addr and o_msi_data are held stable until i_msi_ready=1.
    - Valid is never withdrawn. Changes to ie, dm, pending or target during SEND do not abort or alter the in-flight MSI.
    - On handshake: o_msi_valid=0 next cycle and FSM goes to GAP.
    - Source grant: rr_ptr<=granted index, last_was_gen<=0.
    - genmsi grant: last_was_gen<=1, o_genmsi_busy<=0.
  - GAP:
    - For a source grant, o_clrip_valid=1 and o_clrip_idx=granted index for exactly this cycle.
    - For a genmsi grant, o_clrip_valid stays 0.
    - Always returns to IDLE next cycle, so the cleared pending bit is visible before re-arbitration.
- Address and data
  - ppn_eff = i_msi_base_ppn | {30'b0, hi}.
  - o_msi_addr = {8'b0, ppn_eff, 12'h000}.
  - o_msi_data = {21'b0, eiid}.
- Throughput: one MSI per 3 cycles minimum (IDLE, SEND, GAP) with ready held high.
- Reset mid-SEND drops the request with no clrip pulse; pending remains set in the register file.

Optional Feature:
- Macro: APLIC_MSI_GUEST_EN
  - Defined: ppn_eff = i_msi_base_ppn | ({30'b0, hi} << 6) | {38'b0, gi}, so the target guest index selects the guest interrupt file. genmsi uses gi=0.
  - Undefined: gi bits are ignored and ppn_eff follows the base formula.

Test Plan:
- dm=1, ie=1, base_ppn=0x80000, source 5 pending+enabled, target hi=2, eiid=0x21, ready=1 -> one MSI with addr=0x80002000, data=0x21; o_clrip_valid pulses with idx=5 one cycle after the handshake.
- Sources 3, 7, 9 pending together, rr_ptr=7, ready=1, pending cleared as clrip fires -> grant order 9, 3, 7; no source sent twice.
- genmsi hi=1, eiid=0x40 strobed while source 4 is pending, last_was_gen=0 -> genmsi sent first with busy=1 until its handshake, then source 4; a second strobe while busy is ignored.
- ready held 0 for 10 cycles with ie dropped mid-SEND -> valid, addr and data are constant all 10 cycles; completes when ready=1 and clrip still pulses.
- Source 6 pending with eiid=0, or ie=0 -> no o_msi_valid and no clrip; rr_ptr is unchanged.
- ni_rst=0 asserted during SEND -> all outputs 0 next cycle, busy=0, and no clrip pulse.

Source files
------------

// File: rtl/aplic_msi_sched.sv
// MSI delivery sequencer for one APLIC interrupt domain (domaincfg.DM=1).
// Optional build macro APLIC_MSI_GUEST_EN: target gi selects the guest interrupt file.
module aplic_msi_sched #(
    parameter int NR_SRC = 32,
    parameter int SRC_W  = $clog2(NR_SRC)
) (
    input  logic                   i_clk,
    input  logic                   ni_rst,
    input  logic                   i_domaincfg_ie,
    input  logic                   i_domaincfg_dm,
    input  logic [NR_SRC-1:0]      i_pending,
    input  logic [NR_SRC-1:0]      i_enabled,
    input  logic [NR_SRC*32-1:0]   i_target,
    input  logic [43:0]            i_msi_base_ppn,
    input  logic                   i_genmsi_valid,
    input  logic [13:0]            i_genmsi_hi,
    input  logic [10:0]            i_genmsi_eiid,
    output logic                   o_genmsi_busy,
    output logic                   o_msi_valid,
    input  logic                   i_msi_ready,
    output logic [63:0]            o_msi_addr,
    output logic [31:0]            o_msi_data,
    output logic                   o_clrip_valid,
    output logic [SRC_W-1:0]       o_clrip_idx
);

    // state | meaning
    // IDLE  | arbitrate held genmsi against eligible sources
    // SEND  | MSI write presented, held until i_msi_ready
    // GAP   | clrip pulse for a source grant, then back to IDLE
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SRC_W-1:0]  r_rr_ptr;
    logic              r_last_was_gen;
    logic              r_gen_busy;
    logic [13:0]       r_gen_hi;
    logic [10:0]       r_gen_eiid;
    logic              r_grant_gen;
    logic [SRC_W-1:0]  r_grant_idx;
    logic              r_msi_valid;
    logic [63:0]       r_msi_addr;
    logic [31:0]       r_msi_data;
    logic              r_clrip_valid;
    logic [SRC_W-1:0]  r_clrip_idx;

    logic [NR_SRC-1:0] w_elig;
    logic              w_any_elig;
    logic [SRC_W-1:0]  w_rr_idx;
    logic [SRC_W-1:0]  w_cand;
    logic              w_found;
    int                w_c;
    logic [31:0]       w_sel_tgt;
    logic              w_pick_gen;
    logic              w_load;
    logic              w_hs;
    logic [13:0]       w_ld_hi;
    logic [10:0]       w_ld_eiid;
    logic [43:0]       w_ppn_eff;
    logic              w_unused;

    always_comb begin
        w_elig = '0;
        for (int k = 1; k < NR_SRC; k++) begin
            w_elig[k] = i_pending[k] & i_enabled[k] & i_domaincfg_ie & i_domaincfg_dm
                        & (i_target[32*k +: 11] != 11'd0);
        end
    end

    assign w_any_elig = |w_elig;

    // Round-robin: first eligible index above rr_ptr, wrapping past 0; rr_ptr itself is tried last.
    always_comb begin
        w_c      = 0;
        w_cand   = '0;
        w_found  = 1'b0;
        w_rr_idx = '0;
        for (int off = 1; off <= NR_SRC; off++) begin
            w_c = int'(r_rr_ptr) + off;
            if (w_c >= NR_SRC) begin
                w_c = w_c - NR_SRC;
            end
            w_cand = SRC_W'(w_c);
            if (!w_found && (w_c != 0) && w_elig[w_cand]) begin
                w_rr_idx = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_tgt = '0;
        for (int k = 0; k < NR_SRC; k++) begin
            if (w_rr_idx == SRC_W'(k)) begin
                w_sel_tgt = i_target[32*k +: 32];
            end
        end
    end

    // genmsi wins unless it won last time and a source is waiting.
    assign w_pick_gen = r_gen_busy && !(r_last_was_gen && w_any_elig);
    assign w_ld_hi    = w_pick_gen ? r_gen_hi   : w_sel_tgt[31:18];
    assign w_ld_eiid  = w_pick_gen ? r_gen_eiid : w_sel_tgt[10:0];

`ifdef APLIC_MSI_GUEST_EN
    logic [5:0] w_ld_gi;
    assign w_ld_gi   = w_pick_gen ? 6'd0 : w_sel_tgt[17:12];
    assign w_ppn_eff = i_msi_base_ppn | ({30'b0, w_ld_hi} << 6) | {38'b0, w_ld_gi};
`else
    assign w_ppn_eff = i_msi_base_ppn | {30'b0, w_ld_hi};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_hs        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_gen_busy || w_any_elig) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_msi_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= '0;
            r_last_was_gen <= 1'b0;
            r_gen_busy     <= 1'b0;
            r_gen_hi       <= '0;
            r_gen_eiid     <= '0;
            r_grant_gen    <= 1'b0;
            r_grant_idx    <= '0;
            r_msi_valid    <= 1'b0;
            r_msi_addr     <= '0;
            r_msi_data     <= '0;
            r_clrip_valid  <= 1'b0;
            r_clrip_idx    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_clrip_valid <= 1'b0;
            r_clrip_idx   <= '0;
            if (i_genmsi_valid && !r_gen_busy && i_domaincfg_dm) begin
                r_gen_busy <= 1'b1;
                r_gen_hi   <= i_genmsi_hi;
                r_gen_eiid <= i_genmsi_eiid;
            end
            if (w_load) begin
                r_msi_valid <= 1'b1;
                r_msi_addr  <= {8'b0, w_ppn_eff, 12'h000};
                r_msi_data  <= {21'b0, w_ld_eiid};
                r_grant_gen <= w_pick_gen;
                r_grant_idx <= w_rr_idx;
            end
            if (w_hs) begin
                r_msi_valid <= 1'b0;
                if (r_grant_gen) begin
                    r_last_was_gen <= 1'b1;
                    r_gen_busy     <= 1'b0;
                end else begin
                    r_last_was_gen <= 1'b0;
                    r_rr_ptr       <= r_grant_idx;
                    r_clrip_valid  <= 1'b1;
                    r_clrip_idx    <= r_grant_idx;
                end
            end
        end
    end

    assign o_genmsi_busy = r_gen_busy;
    assign o_msi_valid   = r_msi_valid;
    assign o_msi_addr    = r_msi_addr;
    assign o_msi_data    = r_msi_data;
    assign o_clrip_valid = r_clrip_valid;
    assign o_clrip_idx   = r_clrip_idx;

    // Slot 0 and the reserved/unused target fields do not feed any logic.
    assign w_unused = ^{i_target, i_pending[0], i_enabled[0], w_sel_tgt};

endmodule

// File: tb/tb_aplic_msi_sched.sv
// Directed bench for aplic_msi_sched: vector table of single-source sends plus
// hand sequences for round-robin, genmsi arbitration, stall and reset corners.
module tb_aplic_msi_sched;
    localparam int NR_SRC = 32;
    localparam int SRC_W  = 5;

    logic                  i_clk = 1'b0;
    logic                  ni_rst;
    logic                  ie, dm;
    logic [NR_SRC-1:0]     pend, en;
    logic [NR_SRC*32-1:0]  tgt;
    logic [43:0]           base;
    logic                  gv;
    logic [13:0]           ghi;
    logic [10:0]           geiid;
    logic                  gbusy, mv, mr, cv;
    logic [63:0]           maddr;
    logic [31:0]           mdata;
    logic [SRC_W-1:0]      cidx;

    int n_chk = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    aplic_msi_sched #(.NR_SRC(NR_SRC), .SRC_W(SRC_W)) dut (
        .i_clk(i_clk), .ni_rst(ni_rst),
        .i_domaincfg_ie(ie), .i_domaincfg_dm(dm),
        .i_pending(pend), .i_enabled(en), .i_target(tgt),
        .i_msi_base_ppn(base),
        .i_genmsi_valid(gv), .i_genmsi_hi(ghi), .i_genmsi_eiid(geiid),
        .o_genmsi_busy(gbusy),
        .o_msi_valid(mv), .i_msi_ready(mr),
        .o_msi_addr(maddr), .o_msi_data(mdata),
        .o_clrip_valid(cv), .o_clrip_idx(cidx)
    );

    typedef struct {
        int          src;
        logic [43:0] base;
        logic [13:0] hi;
        logic [10:0] eiid;
        logic        ie;
        logic        dm;
        logic        send;
        logic [63:0] addr_b;
        logic [63:0] addr_g;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_tgt(input int k, input logic [13:0] hi, input logic [5:0] gi, input logic [10:0] eiid);
        tgt[32*k +: 32] = {hi, gi, 1'b0, eiid};
    endtask

    function automatic logic [63:0] pick(input logic [63:0] b, input logic [63:0] g);
`ifdef APLIC_MSI_GUEST_EN
        return g;
`else
        return b;
`endif
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        logic seen_cv;
        base = v.base;
        ie   = v.ie;
        dm   = v.dm;
        mr   = 1'b1;
        set_tgt(v.src, v.hi, 6'd0, v.eiid);
        pend = '0;
        pend[v.src] = 1'b1;
        lat = 0;
        seen_cv = 1'b0;
        while (!mv && lat < 5) begin
            tick;
            lat++;
            seen_cv = seen_cv | cv;
        end
        if (v.send) begin
            chk({nm, "_latency"}, 64'(lat), 1);
            chk({nm, "_addr"}, maddr, pick(v.addr_b, v.addr_g));
            chk({nm, "_data"}, 64'(mdata), 64'(v.eiid));
            tick;
            chk({nm, "_valid_drop"}, 64'(mv), 0);
            chk({nm, "_clrip_valid"}, 64'(cv), 1);
            chk({nm, "_clrip_idx"}, 64'(cidx), 64'(v.src));
            pend = '0;
            tick;
            chk({nm, "_clrip_once"}, 64'(cv), 0);
        end else begin
            chk({nm, "_no_valid"}, 64'(mv), 0);
            chk({nm, "_no_clrip"}, 64'(seen_cv), 0);
            pend = '0;
            ie = 1'b1;
            dm = 1'b1;
            tick;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          ng, nd;
        int          got_idx[3];
        int          got_dat[3];
        int          exp_idx[3];
        logic        seen;
        logic [63:0] hold_addr;

        vecs[0] = '{5,  44'h80000,      14'd2,     11'h21,  1'b1, 1'b1, 1'b1, 64'h80002000,     64'h80080000};
        vecs[1] = '{31, 44'h100000000,  14'h3FFF,  11'h7FF, 1'b1, 1'b1, 1'b1, 64'h100003FFF000, 64'h1000FFFC0000};
        vecs[2] = '{1,  44'h0,          14'd0,     11'h001, 1'b1, 1'b1, 1'b1, 64'h0,            64'h0};
        vecs[3] = '{6,  44'h80000,      14'd3,     11'h000, 1'b1, 1'b1, 1'b0, 64'h0,            64'h0};
        vecs[4] = '{8,  44'h80000,      14'd1,     11'h010, 1'b0, 1'b1, 1'b0, 64'h0,            64'h0};
        vecs[5] = '{8,  44'h80000,      14'd1,     11'h010, 1'b1, 1'b0, 1'b0, 64'h0,            64'h0};
        vecs[6] = '{12, 44'hABC01,      14'h00A,   11'h055, 1'b1, 1'b1, 1'b1, 64'hABC0B000,     64'hABE81000};
        vecs[7] = '{7,  44'h0,          14'd0,     11'h037, 1'b1, 1'b1, 1'b1, 64'h0,            64'h0};
        exp_idx = '{9, 3, 7};

        ni_rst = 1'b0;
        ie = 1'b1; dm = 1'b1;
        pend = '0; en = '1; tgt = '0; base = '0;
        gv = 1'b0; ghi = '0; geiid = '0; mr = 1'b1;
        tick;
        tick;
        chk("rst_valid", 64'(mv), 0);
        chk("rst_addr", maddr, 0);
        chk("rst_data", 64'(mdata), 0);
        chk("rst_clrip", 64'(cv), 0);
        chk("rst_clrip_idx", 64'(cidx), 0);
        chk("rst_busy", 64'(gbusy), 0);
        ni_rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Round robin from rr_ptr=7 over sources 3, 7, 9.
        set_tgt(3, 14'd0, 6'd0, 11'h033);
        set_tgt(7, 14'd0, 6'd0, 11'h037);
        set_tgt(9, 14'd0, 6'd0, 11'h039);
        base = '0;
        pend = '0;
        pend[3] = 1'b1; pend[7] = 1'b1; pend[9] = 1'b1;
        ng = 0; nd = 0;
        for (int c = 0; c < 30 && ng < 3; c++) begin
            tick;
            if (mv && nd < 3) begin
                got_dat[nd] = int'(mdata);
                nd++;
            end
            if (cv) begin
                got_idx[ng] = int'(cidx);
                pend[cidx] = 1'b0;
                ng++;
            end
        end
        chk("rr_grants", 64'(ng), 3);
        chk("rr_msis", 64'(nd), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < ng) chk($sformatf("rr_idx%0d", i), 64'(got_idx[i]), 64'(exp_idx[i]));
            if (i < nd) chk($sformatf("rr_data%0d", i), 64'(got_dat[i]), 64'('h30 + exp_idx[i]));
        end
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            seen = seen | mv;
        end
        chk("rr_no_repeat", 64'(seen), 0);

        // genmsi beats a pending source when last grant was a source.
        base = 44'h80000;
        set_tgt(4, 14'd0, 6'd0, 11'h044);
        pend = '0;
        pend[4] = 1'b1;
        ie = 1'b0;
        mr = 1'b0;
        gv = 1'b1; ghi = 14'd1; geiid = 11'h040;
        tick;
        gv = 1'b0;
        ie = 1'b1;
        chk("gen_busy_set", 64'(gbusy), 1);
        chk("gen_not_yet", 64'(mv), 0);
        tick;
        chk("gen_valid", 64'(mv), 1);
        chk("gen_addr", maddr, pick(64'h80001000, 64'h80040000));
        chk("gen_data", 64'(mdata), 'h40);
        gv = 1'b1; ghi = 14'd3; geiid = 11'h041;
        tick;
        gv = 1'b0;
        chk("gen_busy_hold", 64'(gbusy), 1);
        chk("gen_data_hold", 64'(mdata), 'h40);
        tick;
        mr = 1'b1;
        tick;
        chk("gen_hs_valid", 64'(mv), 0);
        chk("gen_hs_busy", 64'(gbusy), 0);
        chk("gen_no_clrip", 64'(cv), 0);
        tick;
        tick;
        chk("gen_then_src_valid", 64'(mv), 1);
        chk("gen_then_src_data", 64'(mdata), 'h44);
        tick;
        chk("gen_then_src_clrip", 64'(cv), 1);
        chk("gen_then_src_idx", 64'(cidx), 4);
        pend = '0;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick;
            seen = seen | mv | gbusy;
        end
        chk("gen_second_strobe_ignored", 64'(seen), 0);

        // Stall with ready low; ie and target change mid-SEND.
        base = 44'h40000;
        set_tgt(10, 14'h5, 6'd0, 11'h02A);
        mr = 1'b0;
        pend[10] = 1'b1;
        tick;
        chk("stall_valid", 64'(mv), 1);
        hold_addr = pick(64'h40005000, 64'h40140000);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                ie = 1'b0;
                set_tgt(10, 14'h7, 6'd0, 11'h011);
                base = 44'h12345;
            end
            chk($sformatf("stall_valid_c%0d", c), 64'(mv), 1);
            chk($sformatf("stall_addr_c%0d", c), maddr, hold_addr);
            chk($sformatf("stall_data_c%0d", c), 64'(mdata), 'h2A);
            tick;
        end
        mr = 1'b1;
        tick;
        chk("stall_done_valid", 64'(mv), 0);
        chk("stall_clrip", 64'(cv), 1);
        chk("stall_clrip_idx", 64'(cidx), 10);
        pend = '0;
        ie = 1'b1;
        tick;

        // Reset during SEND with a genmsi held.
        base = 44'h80000;
        set_tgt(11, 14'd0, 6'd0, 11'h03B);
        mr = 1'b0;
        pend[11] = 1'b1;
        tick;
        chk("rstsend_valid", 64'(mv), 1);
        gv = 1'b1; ghi = 14'd2; geiid = 11'h022;
        tick;
        gv = 1'b0;
        chk("rstsend_busy", 64'(gbusy), 1);
        ni_rst = 1'b0;
        tick;
        chk("rstsend_out_valid", 64'(mv), 0);
        chk("rstsend_out_addr", maddr, 0);
        chk("rstsend_out_data", 64'(mdata), 0);
        chk("rstsend_out_clrip", 64'(cv), 0);
        chk("rstsend_out_busy", 64'(gbusy), 0);
        ni_rst = 1'b1;
        pend = '0;
        mr = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick;
            seen = seen | cv | mv;
        end
        chk("rstsend_no_clrip", 64'(seen), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
